// File: rtl/uart_fifo_128x8.sv
// 128x8 synchronous FIFO between the APB registers and the UART shifters, two-cycle registered read path.
// Optional sticky overflow/underflow outputs (OVF/UDF) are built when UART_FIFO_ERR_FLAGS_EN is defined.
module uart_fifo_128x8 #(
    parameter int DEPTH     = 128,
    parameter int AW        = 7,
    parameter int DW        = 8,
    parameter int THRESHOLD = 64
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [DW-1:0] DATA_IN,
    input  logic          WRB,
    input  logic          RDB,
    output logic [DW-1:0] DATA_OUT,
    output logic          FULL,
    output logic          EMPTY,
    output logic          GEQTH
`ifdef UART_FIFO_ERR_FLAGS_EN
    ,
    output logic          OVF,
    output logic          UDF
`endif
);

    localparam logic [AW-1:0] FULL_LVL = AW'(DEPTH - 1);
    localparam logic [AW-1:0] TH_LVL   = AW'(THRESHOLD);

    logic [DW-1:0] mem [0:DEPTH-1];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] count_q,  count_d;
    logic [AW-1:0] raddr_q;
    logic          rdb_dly_q;
    logic [DW-1:0] dout_q;
    logic          push_ok;
    logic          pop_ok;

    assign FULL     = (count_q == FULL_LVL);
    assign EMPTY    = (count_q == '0);
    assign GEQTH    = (count_q >= TH_LVL);
    assign DATA_OUT = dout_q;

    // A push while full is still taken when a pop frees a slot in the same cycle.
    always_comb begin
        push_ok  = !WRB && (!FULL || (!RDB && !EMPTY));
        pop_ok   = !RDB && !EMPTY;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
        if (push_ok && !pop_ok) count_d = count_q + AW'(1);
        if (pop_ok && !push_ok) count_d = count_q - AW'(1);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            raddr_q   <= '0;
            rdb_dly_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            raddr_q   <= rd_ptr_q;
            rdb_dly_q <= RDB;
            // Data lands one cycle after the address capture; an empty-pop load is stale but harmless.
            if (!rdb_dly_q) dout_q <= mem[raddr_q];
        end
    end

    // Storage is not reset; a same-address read sees the pre-write word.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr_q] <= DATA_IN;
    end

`ifdef UART_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (!WRB && !push_ok) ovf_q <= 1'b1;
            if (!RDB && EMPTY)    udf_q <= 1'b1;
        end
    end

    assign OVF = ovf_q;
    assign UDF = udf_q;
`endif

endmodule

// File: tb/tb_uart_fifo_128x8.sv
// Directed bench for uart_fifo_128x8: vector table for the basic push/pop path plus
// hand sequences for threshold, full/wrap and reset-during-read.
module tb_uart_fifo_128x8;

    logic       CLK;
    logic       RESET;
    logic [7:0] DATA_IN;
    logic       WRB;
    logic       RDB;
    logic [7:0] DATA_OUT;
    logic       FULL;
    logic       EMPTY;
    logic       GEQTH;
`ifdef UART_FIFO_ERR_FLAGS_EN
    logic       OVF;
    logic       UDF;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_q[$];

    uart_fifo_128x8 dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .DATA_IN  (DATA_IN),
        .WRB      (WRB),
        .RDB      (RDB),
        .DATA_OUT (DATA_OUT),
        .FULL     (FULL),
        .EMPTY    (EMPTY),
        .GEQTH    (GEQTH)
`ifdef UART_FIFO_ERR_FLAGS_EN
        ,
        .OVF      (OVF),
        .UDF      (UDF)
`endif
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        WRB   = 1'b1;
        RDB   = 1'b1;
        step();
        step();
        RESET = 1'b0;
        exp_q.delete();
    endtask

    // driver tasks (also keep the scoreboard model in step)
    task automatic drive(input logic wrb, input logic rdb, input logic [7:0] din);
        logic model_full;
        logic model_empty;
        model_full  = (exp_q.size() == 127);
        model_empty = (exp_q.size() == 0);
        WRB     = wrb;
        RDB     = rdb;
        DATA_IN = din;
        step();
        if (!rdb && !model_empty) void'(exp_q.pop_front());
        if (!wrb && (!model_full || (!rdb && !model_empty))) exp_q.push_back(din);
        WRB = 1'b1;
        RDB = 1'b1;
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_empty"}, 8'(EMPTY), 8'(exp_q.size() == 0));
        check({tag, "_full"},  8'(FULL),  8'(exp_q.size() == 127));
        check({tag, "_geqth"}, 8'(GEQTH), 8'(exp_q.size() >= 64));
    endtask

    // Back-to-back pops until empty; each word appears one edge after its pop.
    task automatic drain(input string tag);
        logic [7:0] prev;
        logic       prev_v;
        logic [7:0] cur;
        prev_v = 1'b0;
        prev   = '0;
        while (exp_q.size() != 0) begin
            cur = exp_q[0];
            WRB = 1'b1;
            RDB = 1'b0;
            step();
            void'(exp_q.pop_front());
            if (prev_v) check({tag, "_dout"}, DATA_OUT, prev);
            prev   = cur;
            prev_v = 1'b1;
        end
        RDB = 1'b1;
        step();
        if (prev_v) check({tag, "_dout_last"}, DATA_OUT, prev);
        check({tag, "_empty_end"}, 8'(EMPTY), 8'h01);
    endtask

    typedef struct {
        logic       wrb;
        logic       rdb;
        logic [7:0] din;
        logic       e_empty;
        logic       e_full;
        logic       e_geqth;
        logic       chk_dout;
        logic [7:0] e_dout;
    } vec_t;

    vec_t vecs[13];

    initial begin
        WRB = 1'b1;
        RDB = 1'b1;
        DATA_IN = '0;
        RESET = 1'b1;

        //          wrb   rdb   din    empty full  geqth chk   dout
        vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1]  = '{1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
        vecs[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h22};
        vecs[6]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33};
        vecs[7]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33};
        vecs[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33};
        vecs[9]  = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[10] = '{1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44};
        vecs[12] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h44};

        // reset state
        do_reset();
        check("rst_empty", 8'(EMPTY), 8'h01);
        check("rst_full",  8'(FULL),  8'h00);
        check("rst_geqth", 8'(GEQTH), 8'h00);
        check("rst_dout",  DATA_OUT,  8'h00);
`ifdef UART_FIFO_ERR_FLAGS_EN
        check("rst_ovf", 8'(OVF), 8'h00);
        check("rst_udf", 8'(UDF), 8'h00);
`endif

        // vector table: ordered push/pop, pop on empty, push+pop on empty
        for (int i = 0; i < 13; i++) begin
            WRB     = vecs[i].wrb;
            RDB     = vecs[i].rdb;
            DATA_IN = vecs[i].din;
            step();
            check($sformatf("vec%0d_empty", i), 8'(EMPTY), 8'(vecs[i].e_empty));
            check($sformatf("vec%0d_full", i),  8'(FULL),  8'(vecs[i].e_full));
            check($sformatf("vec%0d_geqth", i), 8'(GEQTH), 8'(vecs[i].e_geqth));
            if (vecs[i].chk_dout) check($sformatf("vec%0d_dout", i), DATA_OUT, vecs[i].e_dout);
        end
        WRB = 1'b1;
        RDB = 1'b1;
`ifdef UART_FIFO_ERR_FLAGS_EN
        check("udf_sticky", 8'(UDF), 8'h01);
        check("ovf_clear",  8'(OVF), 8'h00);
        step();
        check("udf_still", 8'(UDF), 8'h01);
`endif

        // threshold crossing
        do_reset();
`ifdef UART_FIFO_ERR_FLAGS_EN
        check("udf_reset_clr", 8'(UDF), 8'h00);
`endif
        for (int i = 0; i < 63; i++) drive(1'b0, 1'b1, 8'(i + 8'h40));
        check("th63_geqth", 8'(GEQTH), 8'h00);
        drive(1'b0, 1'b1, 8'hC0);
        check("th64_geqth", 8'(GEQTH), 8'h01);
        drive(1'b1, 1'b0, 8'h00);
        check("th_pop_geqth", 8'(GEQTH), 8'h00);
        check_flags("th_pop");

        // fill to capacity, rejected push, push+pop while full across the pointer wrap
        do_reset();
        for (int i = 0; i < 126; i++) drive(1'b0, 1'b1, 8'(i * 7 + 3));
        check("fill126_full", 8'(FULL), 8'h00);
        drive(1'b0, 1'b1, 8'hEE);
        check("fill127_full",  8'(FULL),  8'h01);
        check("fill127_geqth", 8'(GEQTH), 8'h01);
        drive(1'b0, 1'b1, 8'hBD);
        check("rej_push_full", 8'(FULL), 8'h01);
        check("rej_push_size", 8'(exp_q.size()), 8'd127);
`ifdef UART_FIFO_ERR_FLAGS_EN
        check("ovf_set", 8'(OVF), 8'h01);
`endif
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 8'(8'hA0 + i));
            check($sformatf("pp%0d_full", i), 8'(FULL), 8'h01);
        end
        drain("wrap");

        // reset while 10 entries are stored and a read is in flight
        do_reset();
        for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 8'(8'h80 + i));
        RDB = 1'b0;
        step();
        step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        RDB   = 1'b1;
        exp_q.delete();
        check("midrst_empty", 8'(EMPTY), 8'h01);
        check("midrst_full",  8'(FULL),  8'h00);
        check("midrst_geqth", 8'(GEQTH), 8'h00);
        check("midrst_dout",  DATA_OUT,  8'h00);
        drive(1'b0, 1'b1, 8'h5A);
        drive(1'b1, 1'b0, 8'h00);
        step();
        check("post_rst_dout",  DATA_OUT,  8'h5A);
        check("post_rst_empty", 8'(EMPTY), 8'h01);

        // final report
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_fifo_128x8.md
Name: uart_fifo_128x8

Overview:
- Synchronous 128-entry x 8-bit FIFO buffering UART transmit/receive bytes between the APB register interface and the UART shift logic.
- Contains a write pointer, read pointer and occupancy counter, plus a dual-port RAM behavioural model.
- The RAM has a registered read address and a registered data output.
- Provides FULL, EMPTY and a programmable threshold flag (GEQTH).

Parameters:
DEPTH, 128, number of storage locations (power of two)
AW, 7, pointer/count width, log2(DEPTH)
DW, 8, data width
THRESHOLD, 64, AW-bit level compared against occupancy to drive GEQTH

Ports:
CLK  input  1  single clock; all state changes on rising edge
RESET  input  1  synchronous active-high reset
DATA_IN  input  DW  write data, sampled when WRB=0
WRB  input  1  active-low write strobe, one push per cycle while low
RDB  input  1  active-low read strobe, one pop per cycle while low
DATA_OUT  output  DW  registered read data
FULL  output  1  high when count == DEPTH-1
EMPTY  output  1  high when count == 0
GEQTH  output  1  high when count >= THRESHOLD

Behaviour:
- Reset (RESET=1 at a rising CLK edge):
  - wr_ptr, rd_ptr and count go to 0.
  - DATA_OUT goes to 0; internal rdb_d goes to 0.
  - FULL=0, EMPTY=1, GEQTH=(THRESHOLD==0).
  - RAM contents are not cleared.
  - Reset has priority over every other event, including mid-transfer.
- Flag timing: flags are combinational decodes of count, so they update in the same cycle count changes.
- Usable capacity is DEPTH-1 (127) entries; FULL asserts at 127.
- Push is accepted when WRB=0 and (FULL=0 or RDB=0 with EMPTY=0):
  - mem[wr_ptr] <= DATA_IN.
  - wr_ptr increments modulo DEPTH (127 -> 0).
- Pop is accepted when RDB=0 and EMPTY=0:
  - rd_ptr increments modulo DEPTH.
- Rejected operations change no state:
  - push while FULL with no accepted pop;
  - pop while EMPTY.
- Count update:
  - +1 for accepted push only;
  - -1 for accepted pop only;
  - unchanged when both are accepted in the same cycle.
- Simultaneous push and pop while EMPTY: only the push is accepted, so count becomes 1.
- Read path (two-cycle latency):
  - At edge k, RDB=0 with EMPTY=0 pops the word at rd_ptr=p.
  - At the same edge, the RAM address register captures p and rdb_d <= RDB.
  - At edge k+1, because rdb_d==0, DATA_OUT <= mem[p].
  - When rdb_d==1, DATA_OUT holds its value.
  - A pop on an empty FIFO still loads DATA_OUT from the current RAM output, with a stale but harmless value.
- Back-to-back pops: DATA_OUT steps through consecutive entries one cycle after each address capture.
- Read-during-write to the same address returns the old data. This case cannot occur for valid entries.
- Width rules:
  - Pointers and count are AW bits.
  - The threshold compare is unsigned.

Optional Feature:
- Macro: UART_FIFO_ERR_FLAGS_EN.
- When defined, two extra outputs are added:
  - OVF: sticky, set on a rejected push.
  - UDF: sticky, set on a rejected pop.
- Both flags clear only on RESET.
- When undefined, neither port nor its logic exists; rejected operations are silently dropped.

Test Plan:
- Reset then idle -> EMPTY=1, FULL=0, GEQTH=0, DATA_OUT=0x00.
- Push 0x11, 0x22, 0x33, then pop three back-to-back -> DATA_OUT=0x11, 0x22, 0x33 on edges k+1, k+2, k+3; EMPTY=1 after the third pop.
- Push 64 bytes -> GEQTH rises exactly on the 64th push; one pop drops it (count 63).
- Push 127 bytes -> FULL=1; a 128th push alone is dropped and count stays 127. Simultaneous push and pop keeps count at 127, and the FIFO order is preserved over the wrap of wr_ptr 127 -> 0.
- Pop while empty -> count stays 0 and EMPTY stays 1. With the macro defined, UDF=1 and stays set until RESET.
- RESET asserted with 10 entries stored and a read in flight -> next cycle count=0, EMPTY=1, DATA_OUT=0x00.
